mdu_controller: RTL
===================

# mdu_controller

Sequencing controller for the RV32M multiply/divide unit in the execute stage. Accepts one M-extension operation at a time from the ID/EX register. Runs a two-cycle multiply or an iterative 32-step restoring divide. Holds the pipeline with a stall signal until the registered result is returned alongside the ALU result path.

## Interface
- XLEN, 32, operand/result width; only 32 is supported.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset: one clock; reset is asynchronous and active-low.
- start  in  1  valid M-extension op in EX (opcode R-type, func7 = 0000001).
- func3  in  3  M op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  in  XLEN  rs1 value (forwarded).
- op_b  in  XLEN  rs2 value (forwarded).
- flush  in  1  kill in-flight op (branch mispredict / trap).
- stall  out  1  freeze IF/ID/EX while op pending.
- busy  out  1  state != IDLE.
- result  out  XLEN  final value, registered.
- result_valid  out  1  one-cycle pulse; result valid this cycle.

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - start && !flush: capture func3, op_a, op_b.
  - Then go to MUL (func3[2]=0), DIV (normal divide) or DONE (divide special case).
- MUL: form the 64-bit product in one cycle.
  - Signedness: MUL/MULH signed×signed; MULHSU signed×unsigned; MULHU unsigned×unsigned.
  - MUL returns bits [31:0]; the others return bits [63:32].
  - Register the result, then go to DONE.
- Divide special cases, resolved in IDLE:
  - op_b == 0: quotient 0xFFFFFFFF; remainder = op_a.
  - Signed overflow (op_a = 0x80000000, op_b = 0xFFFFFFFF, DIV/REM only): quotient 0x80000000; remainder 0.
- DIV:
  - Operate on magnitudes; signed ops take absolute values.
  - 32 restoring iterations with a 5-bit counter, 31 down to 0.
  - Counter == 0: go to DONE.
  - On entry to DONE, correct signs: quotient negated if sign(a) != sign(b); remainder takes the sign of op_a.
- DONE: result_valid = 1, then return to IDLE.
- start while busy: ignored. The pipeline is stalled, so it cannot legally occur.
- flush in any non-IDLE state: next state IDLE; result_valid suppressed; result keeps its old value.
- start && flush in the same IDLE cycle: flush wins; op dropped.

## Timing
- Reset values: state IDLE, result 0, result_valid 0, busy 0, stall 0, counter 0.
- Reset is asynchronous and may occur mid-operation; it aborts the op with no result_valid.
- Cycle 0 is the cycle with start high in IDLE.
- Latency to result_valid:
  - MUL*: cycle 2.
  - DIV/REM normal: cycle 33.
  - Special case: cycle 1.
- stall is combinational: (start && state == IDLE && !flush) || (busy && state != DONE && !flush).
- In DONE, stall = 0. EX captures result and the pipeline advances in the same cycle.
- busy is registered from state.
- Back-to-back: start may be asserted in the cycle after DONE.

## Configuration
- MDU_DIV_EARLY_OUT_EN defined:
  - In IDLE, an unsigned or magnitude compare |op_a| < |op_b| (op_b != 0) goes directly to DONE.
  - Quotient 0; remainder = op_a; result_valid at cycle 1.
- Undefined: such ops take the full 33-cycle path. Results are bit-identical either way.

## Structure
- defines.vh holds:
  - func3 constants MDU_MUL … MDU_REMU.
  - State encodings MDU_IDLE/MUL/DIV/DONE (2 bits).
  - MDU_DIV_CYCLES = 32.
- One sub-module, mdu_div_core:
  - Holds the remainder/quotient registers and the iteration counter.
  - Driven by load/step controls from the controller.
  - Reports last_step.
- The multiplier stays inline.

## Test plan
- MULH 0xFFFFFFFF × 0x00000002: result_valid at cycle 2; result 0xFFFFFFFF; stall high in cycles 0–1 and low in cycle 2.
- DIV 0xFFFFFFF9 (−7) by 2: result_valid at cycle 33; result 0xFFFFFFFD. The same operands with REM give 0xFFFFFFFF.
- DIVU 100 by 0: result 0xFFFFFFFF at cycle 1. REM 0x80000000 by 0xFFFFFFFF: result 0 at cycle 1.
- DIVU 1000 by 7, then flush at cycle 10: state returns to IDLE at cycle 11; no result_valid; stall low from cycle 10.
- rst_n low at cycle 15 of a DIVU: all outputs are 0 immediately. After release, MUL 3×5 gives 15 at cycle 2.
- DIVU 3 by 10: result 0 at cycle 1 with MDU_DIV_EARLY_OUT_EN, and at cycle 33 without it.

Source files
------------

// File: rtl/mdu_controller_pkg.sv
// Shared types and constants for the RV32M multiply/divide controller.
package mdu_controller_pkg;

    localparam int XLEN           = 32;
    localparam int MDU_DIV_CYCLES = 32;
    localparam int MDU_CNT_W      = 5;

    // func3 encodings of the M-extension ops
    typedef enum logic [2:0] {
        MDU_MUL    = 3'b000,
        MDU_MULH   = 3'b001,
        MDU_MULHSU = 3'b010,
        MDU_MULHU  = 3'b011,
        MDU_DIV    = 3'b100,
        MDU_DIVU   = 3'b101,
        MDU_REM    = 3'b110,
        MDU_REMU   = 3'b111
    } mdu_op_e;

    // Controller state encodings
    typedef enum logic [1:0] {
        MDU_ST_IDLE = 2'd0,
        MDU_ST_MUL  = 2'd1,
        MDU_ST_DIV  = 2'd2,
        MDU_ST_DONE = 2'd3
    } mdu_state_e;

    // Two's-complement magnitude when the value is treated as signed
    function automatic logic [XLEN-1:0] mdu_mag(input logic [XLEN-1:0] v, input logic is_signed);
        return (is_signed && v[XLEN-1]) ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Restoring divider datapath: remainder/quotient registers and the
// 31..0 iteration counter, sequenced by load/step from the controller.
module mdu_div_core
    import mdu_controller_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quo_next,
    output logic [XLEN-1:0] rem_next,
    output logic            last_step
);

    logic [XLEN-1:0]      rem_q;
    logic [XLEN-1:0]      quo_q;
    logic [XLEN-1:0]      div_q;
    logic [MDU_CNT_W-1:0] cnt_q;
    logic [XLEN:0]        shifted;
    logic [XLEN:0]        diff;

    // One restoring step: shift in the next dividend bit, trial-subtract the divisor
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        rem_next = '0;
        quo_next = '0;
        shifted  = {rem_q, quo_q[XLEN-1]};
        diff     = shifted - {1'b0, div_q};
        if (!diff[XLEN]) begin
            rem_next = diff[XLEN-1:0];
            quo_next = {quo_q[XLEN-2:0], 1'b1};
        end else begin
            rem_next = shifted[XLEN-1:0];
            quo_next = {quo_q[XLEN-2:0], 1'b0};
        end
    end

    assign last_step = (cnt_q == '0);

    // Divider registers: load magnitudes, then advance one bit per step
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state uses non-blocking assignments so all flops update together at the edge.
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            div_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
            div_q <= divisor;
            cnt_q <= MDU_CNT_W'(MDU_DIV_CYCLES - 1);
        end else if (step) begin
            rem_q <= rem_next;
            quo_q <= quo_next;
            if (cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/mdu_controller.sv
// RV32M multiply/divide sequencing controller for the execute stage.
// Optional feature: define MDU_DIV_EARLY_OUT_EN to finish divides with
// |op_a| < |op_b| in one cycle (results are identical either way).
module mdu_controller
    import mdu_controller_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic [XLEN-1:0] result,
    output logic            result_valid
);

    mdu_state_e      state_q, state_d;
    mdu_op_e         op_q;
    logic [XLEN-1:0] a_q, b_q;
    logic [XLEN-1:0] result_q, result_d;
    logic            busy_q;

    logic            accept;
    logic            in_signed, in_rem;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf, early, special;
    logic [XLEN-1:0] special_res;

    logic [63:0]     a_ext, b_ext, prod;
    logic [XLEN-1:0] mul_res;
    logic            q_signed, neg_quo, neg_rem;
    logic [XLEN-1:0] div_res;

    logic            div_load, div_step, div_last;
    logic [XLEN-1:0] quo_next, rem_next;

    assign accept    = (state_q == MDU_ST_IDLE) && start && !flush;
    assign in_signed = !func3[0];
    assign in_rem    = func3[1];
    assign a_mag     = mdu_mag(op_a, in_signed);
    assign b_mag     = mdu_mag(op_b, in_signed);
    assign div_zero  = (op_b == '0);
    assign div_ovf   = in_signed && (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);

`ifdef MDU_DIV_EARLY_OUT_EN
    assign early = !div_zero && (a_mag < b_mag);
`else
    assign early = 1'b0;
`endif

    assign special = div_zero || div_ovf || early;

    // Divide results that are known without iterating
    always_comb begin
        special_res = '0;
        if (div_zero) begin
            special_res = in_rem ? op_a : '1;
        end else if (div_ovf) begin
            special_res = in_rem ? '0 : 32'h8000_0000;
        end else begin
            special_res = in_rem ? op_a : '0;
        end
    end

    // 64-bit product; sign extension chosen per op, low 64 bits are exact
    assign a_ext   = {{32{(op_q != MDU_MULHU) && a_q[XLEN-1]}}, a_q};
    assign b_ext   = {{32{((op_q == MDU_MUL) || (op_q == MDU_MULH)) && b_q[XLEN-1]}}, b_q};
    assign prod    = a_ext * b_ext;
    assign mul_res = (op_q == MDU_MUL) ? prod[31:0] : prod[63:32];

    // Sign correction applied to the final divider step
    assign q_signed = !op_q[0];
    assign neg_quo  = q_signed && (a_q[XLEN-1] ^ b_q[XLEN-1]);
    assign neg_rem  = q_signed && a_q[XLEN-1];
    assign div_res  = op_q[1] ? (neg_rem ? (~rem_next + 1'b1) : rem_next)
                              : (neg_quo ? (~quo_next + 1'b1) : quo_next);

    mdu_div_core u_div_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (div_load),
        .step      (div_step),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quo_next  (quo_next),
        .rem_next  (rem_next),
        .last_step (div_last)
    );

    // Next-state, divider control and result update
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        div_load = 1'b0;
        div_step = 1'b0;
        unique case (state_q)
            MDU_ST_IDLE: begin
                if (accept) begin
                    if (!func3[2]) begin
                        state_d = MDU_ST_MUL;
                    end else if (special) begin
                        state_d  = MDU_ST_DONE;
                        result_d = special_res;
                    end else begin
                        state_d  = MDU_ST_DIV;
                        div_load = 1'b1;
                    end
                end
            end
            MDU_ST_MUL: begin
                if (flush) begin
                    state_d = MDU_ST_IDLE;
                end else begin
                    state_d  = MDU_ST_DONE;
                    result_d = mul_res;
                end
            end
            MDU_ST_DIV: begin
                if (flush) begin
                    state_d = MDU_ST_IDLE;
                end else begin
                    div_step = 1'b1;
                    if (div_last) begin
                        state_d  = MDU_ST_DONE;
                        result_d = div_res;
                    end
                end
            end
            MDU_ST_DONE: state_d = MDU_ST_IDLE;
            default:     state_d = MDU_ST_IDLE;
        endcase
    end

    // State, captured operands, result and busy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= MDU_ST_IDLE;
            op_q     <= MDU_MUL;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            busy_q   <= (state_d != MDU_ST_IDLE);
            if (accept) begin
                op_q <= mdu_op_e'(func3);
                a_q  <= op_a;
                b_q  <= op_b;
            end
        end
    end

    assign busy         = busy_q;
    assign result       = result_q;
    assign result_valid = (state_q == MDU_ST_DONE) && !flush;
    assign stall        = (start && (state_q == MDU_ST_IDLE) && !flush) ||
                          (busy_q && (state_q != MDU_ST_DONE) && !flush);

endmodule
